// File: rtl/helper_memory_arbiter_pkg.sv
// Shared types and defaults for the helper memory arbiter.
//   owner_t          : which port owns the response presented next cycle
//   DEF_*            : default widths and starvation limit
//   WRITE_ACK_DATA   : data word returned with a write acknowledge
package helper_memory_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INS  = 2'd1,
    OWN_DAT  = 2'd2
  } owner_t;

  localparam int unsigned DEF_ADDRES_BIT   = 32;
  localparam int unsigned DEF_DATA_BIT     = 32;
  localparam int unsigned DEF_STARVE_LIMIT = 4;

  localparam int unsigned WRITE_ACK_DATA   = 0;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive cycles a pending instruction request has
// been denied. Raises force_ins once the count reaches STARVE_LIMIT.
//   clk, rst_n  : clock, asynchronous active-low reset
//   ins_valid   : instruction request pending
//   ins_accept  : instruction request granted this cycle
//   force_ins   : instruction port must win this cycle
module arb_starve_counter
  import helper_memory_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ins_valid,
  input  logic ins_accept,
  output logic force_ins
);

  localparam int unsigned      CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!ins_valid || ins_accept) begin
      cnt <= '0;
    end else if (cnt < LIMIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign force_ins = ins_valid && (cnt >= LIMIT);

endmodule

// File: rtl/helper_memory_arbiter.sv
// Shares a single-port helper memory between the instruction fetch port and
// the data port. One access per cycle; the data port has fixed priority
// unless the starvation guard forces an instruction grant. Read data is
// captured into per-port response registers and presented the cycle after
// accept (no response backpressure).
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   ins_req_* / ins_rsp_*    : instruction read request / response
//   ins_flush_i              : drop the instruction response due next cycle
//   dat_req_* / dat_rsp_*    : data read/write request / response
//   mem_*                    : memory address, write data, write enable, read data
module helper_memory_arbiter
  import helper_memory_arbiter_pkg::*;
#(
  parameter int unsigned ADDRES_BIT   = DEF_ADDRES_BIT,
  parameter int unsigned DATA_BIT     = DEF_DATA_BIT,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  input  logic                  ins_req_valid_i,
  input  logic [ADDRES_BIT-1:0] ins_addr_i,
  output logic                  ins_req_ready_o,
  input  logic                  ins_flush_i,
  output logic                  ins_rsp_valid_o,
  output logic [DATA_BIT-1:0]   ins_rsp_data_o,

  input  logic                  dat_req_valid_i,
  input  logic                  dat_we_i,
  input  logic [ADDRES_BIT-1:0] dat_addr_i,
  input  logic [DATA_BIT-1:0]   dat_wdata_i,
  output logic                  dat_req_ready_o,
  output logic                  dat_rsp_valid_o,
  output logic [DATA_BIT-1:0]   dat_rsp_data_o,

  output logic [ADDRES_BIT-1:0] mem_addres_o,
  output logic [DATA_BIT-1:0]   mem_write_data_o,
  output logic                  mem_write_enable_o,
  input  logic [DATA_BIT-1:0]   mem_read_data_i
);

  logic                  force_ins;
  logic                  ins_grant;
  logic                  dat_grant;
  logic [ADDRES_BIT-1:0] last_addr;
  owner_t                owner;
  logic                  ins_flushed;
  logic [DATA_BIT-1:0]   ins_data;
  logic [DATA_BIT-1:0]   dat_data;

  arb_starve_counter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .ins_valid  (ins_req_valid_i),
    .ins_accept (ins_grant),
    .force_ins  (force_ins)
  );

  // Grants are qualified with reset so nothing is accepted (and no write
  // reaches the memory) while reset is held.
  always_comb begin
    dat_grant = rst_ni && dat_req_valid_i && !force_ins;
    ins_grant = rst_ni && ins_req_valid_i && !dat_grant;
  end

  assign ins_req_ready_o    = ins_grant;
  assign dat_req_ready_o    = dat_grant;

  assign mem_addres_o       = dat_grant ? dat_addr_i :
                              ins_grant ? ins_addr_i : last_addr;
  assign mem_write_data_o   = dat_wdata_i;
  assign mem_write_enable_o = dat_grant && dat_we_i && rst_ni;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner       <= OWN_NONE;
      last_addr   <= '0;
      ins_flushed <= 1'b0;
      ins_data    <= '0;
      dat_data    <= '0;
    end else if (ins_grant) begin
      owner       <= OWN_INS;
      last_addr   <= ins_addr_i;
      ins_flushed <= ins_flush_i;
      ins_data    <= mem_read_data_i;
    end else if (dat_grant) begin
      owner       <= OWN_DAT;
      last_addr   <= dat_addr_i;
      dat_data    <= dat_we_i ? DATA_BIT'(WRITE_ACK_DATA) : mem_read_data_i;
    end else begin
      owner       <= OWN_NONE;
    end
  end

  // A flush in the presentation cycle must suppress the response without
  // waiting a cycle, so it gates the registered owner combinationally.
  assign ins_rsp_valid_o = (owner == OWN_INS) && !ins_flushed && !ins_flush_i;
  assign dat_rsp_valid_o = (owner == OWN_DAT);
  assign ins_rsp_data_o  = ins_data;
  assign dat_rsp_data_o  = dat_data;

endmodule

// File: tb/tb_helper_memory_arbiter.sv
module tb_helper_memory_arbiter;

  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ins_req_valid, ins_req_ready, ins_flush, ins_rsp_valid;
  logic [31:0] ins_addr, ins_rsp_data;
  logic        dat_req_valid, dat_we, dat_req_ready, dat_rsp_valid;
  logic [31:0] dat_addr, dat_wdata, dat_rsp_data;
  logic [31:0] mem_addres, mem_write_data, mem_read_data;
  logic        mem_write_enable;

  always #5 clk = ~clk;

  helper_memory_arbiter #(
    .ADDRES_BIT   (32),
    .DATA_BIT     (32),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .ins_req_valid_i    (ins_req_valid),
    .ins_addr_i         (ins_addr),
    .ins_req_ready_o    (ins_req_ready),
    .ins_flush_i        (ins_flush),
    .ins_rsp_valid_o    (ins_rsp_valid),
    .ins_rsp_data_o     (ins_rsp_data),
    .dat_req_valid_i    (dat_req_valid),
    .dat_we_i           (dat_we),
    .dat_addr_i         (dat_addr),
    .dat_wdata_i        (dat_wdata),
    .dat_req_ready_o    (dat_req_ready),
    .dat_rsp_valid_o    (dat_rsp_valid),
    .dat_rsp_data_o     (dat_rsp_data),
    .mem_addres_o       (mem_addres),
    .mem_write_data_o   (mem_write_data),
    .mem_write_enable_o (mem_write_enable),
    .mem_read_data_i    (mem_read_data)
  );

  // Environment memory: 256 words, aliased on address bits [9:2].
  logic [31:0] mem [256];
  assign mem_read_data = mem[mem_addres[9:2]];
  always @(posedge clk) if (mem_write_enable) mem[mem_addres[9:2]] <= mem_write_data;

  // Reference model state
  logic [31:0] model_mem [256];
  logic        p_valid, p_ins, p_flush;
  logic [31:0] p_data, m_last_addr;
  int unsigned wait_cnt;
  logic        g_ir, g_dr;

  // Sampled DUT outputs of the last step
  logic        s_ir, s_dr, s_we, s_irv, s_drv;
  logic [31:0] s_ird, s_drd, s_addr;

  int unsigned n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, advance model.
  task automatic step(input logic iv, input logic [31:0] ia, input logic fl,
                      input logic dv, input logic dwe, input logic [31:0] da,
                      input logic [31:0] dw);
    logic        e_ir, e_dr, e_irv, e_drv;
    logic [31:0] e_addr;
    ins_req_valid = iv; ins_addr = ia; ins_flush = fl;
    dat_req_valid = dv; dat_we = dwe; dat_addr = da; dat_wdata = dw;
    @(negedge clk);
    s_ir = ins_req_ready; s_dr = dat_req_ready; s_we = mem_write_enable;
    s_irv = ins_rsp_valid; s_drv = dat_rsp_valid; s_ird = ins_rsp_data;
    s_drd = dat_rsp_data; s_addr = mem_addres;
    if (!rst_n) begin
      p_valid = 1'b0; wait_cnt = 0; m_last_addr = '0;
    end
    e_irv = p_valid && p_ins && !p_flush && !fl;
    e_drv = p_valid && !p_ins;
    chk("ins_rsp_valid", 32'(s_irv), 32'(e_irv));
    chk("dat_rsp_valid", 32'(s_drv), 32'(e_drv));
    if (e_irv) chk("ins_rsp_data", s_ird, p_data);
    if (e_drv) chk("dat_rsp_data", s_drd, p_data);
    // Data wins unless the instruction request has waited LIMIT cycles.
    e_dr   = rst_n && dv && !(iv && wait_cnt >= LIMIT);
    e_ir   = rst_n && iv && !e_dr;
    e_addr = e_dr ? da : (e_ir ? ia : m_last_addr);
    chk("ins_req_ready", 32'(s_ir), 32'(e_ir));
    chk("dat_req_ready", 32'(s_dr), 32'(e_dr));
    chk("mem_write_enable", 32'(s_we), 32'(e_dr && dwe));
    chk("mem_addres", s_addr, e_addr);
    if (e_dr && dwe) chk("mem_write_data", mem_write_data, dw);
    p_valid = e_ir || e_dr; p_ins = e_ir; p_flush = fl;
    if (e_ir) p_data = model_mem[ia[9:2]];
    else if (e_dr) begin
      p_data = dwe ? 32'h0 : model_mem[da[9:2]];
      if (dwe) model_mem[da[9:2]] = dw;
    end
    if (e_ir || e_dr) m_last_addr = e_addr;
    if (!rst_n || !iv || e_ir) wait_cnt = 0;
    else if (wait_cnt < LIMIT) wait_cnt++;
    g_ir = e_ir; g_dr = e_dr;
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic fl);
    step(1'b0, 32'h0, fl, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'h8000_0000 | (32'($urandom_range(0, 63)) << 2);
  endfunction

  typedef struct {
    logic iv, dv, dwe;
    logic exp_ir, exp_dr, exp_we;
  } vec_t;
  vec_t tbl[$];

  logic        ri_v, rd_v, rd_we;
  logic [31:0] ri_a, rd_a, rd_w;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'hC0DE_0000 + 32'(i);
      model_mem[i] = 32'hC0DE_0000 + 32'(i);
    end
    mem[4] = 32'h0000_0013; model_mem[4] = 32'h0000_0013;
    p_valid = 0; p_ins = 0; p_flush = 0; p_data = 0; m_last_addr = 0; wait_cnt = 0;
    g_ir = 0; g_dr = 0;
    rst_n = 1'b0;
    ins_req_valid = 0; ins_addr = 0; ins_flush = 0;
    dat_req_valid = 0; dat_we = 0; dat_addr = 0; dat_wdata = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset ins_rsp_valid", 32'(ins_rsp_valid), 32'h0);
    chk("reset dat_rsp_valid", 32'(dat_rsp_valid), 32'h0);
    chk("reset ins_rsp_data", ins_rsp_data, 32'h0);
    chk("reset dat_rsp_data", dat_rsp_data, 32'h0);
    chk("reset mem_addres", mem_addres, 32'h0);
    chk("reset mem_write_enable", 32'(mem_write_enable), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Instruction-only read
    step(1, 32'h8000_0010, 0, 0, 0, 0, 0);
    chk("ins read ready", 32'(s_ir), 32'h1);
    idle(0);
    chk("ins read rsp_valid", 32'(s_irv), 32'h1);
    chk("ins read rsp_data", s_ird, 32'h0000_0013);
    chk("ins read no dat rsp", 32'(s_drv), 32'h0);

    // Data write then read-back
    step(0, 0, 0, 1, 1, 32'h8000_0020, 32'hDEAD_BEEF);
    chk("dat write we", 32'(s_we), 32'h1);
    step(0, 0, 0, 1, 0, 32'h8000_0020, 32'h0);
    chk("write ack valid", 32'(s_drv), 32'h1);
    chk("write ack data", s_drd, 32'h0);
    chk("read we low", 32'(s_we), 32'h0);
    idle(0);
    chk("readback valid", 32'(s_drv), 32'h1);
    chk("readback data", s_drd, 32'hDEAD_BEEF);

    // Table: both ports saturating, then single-port rows
    tbl.push_back('{0, 0, 0, 0, 0, 0});
    for (int i = 0; i < 10; i++)
      tbl.push_back('{1, 1, 0, (i % 5 == 4), (i % 5 != 4), 0});
    tbl.push_back('{1, 0, 0, 1, 0, 0});
    tbl.push_back('{0, 1, 1, 0, 1, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 0});
    foreach (tbl[i]) begin
      step(tbl[i].iv, 32'h8000_0100, 0, tbl[i].dv, tbl[i].dwe,
           tbl[i].dwe ? 32'h8000_0108 : 32'h8000_0104, 32'hA5A5_0001);
      chk($sformatf("tbl%0d ins_ready", i), 32'(s_ir), 32'(tbl[i].exp_ir));
      chk($sformatf("tbl%0d dat_ready", i), 32'(s_dr), 32'(tbl[i].exp_dr));
      chk($sformatf("tbl%0d we", i), 32'(s_we), 32'(tbl[i].exp_we));
    end

    // Flush in response cycle, flush in accept cycle, then normal read
    step(1, 32'h8000_0030, 0, 0, 0, 0, 0);
    idle(1);
    chk("flush rsp cycle", 32'(s_irv), 32'h0);
    step(1, 32'h8000_0030, 1, 0, 0, 0, 0);
    idle(0);
    chk("flush accept cycle", 32'(s_irv), 32'h0);
    step(1, 32'h8000_0034, 0, 0, 0, 0, 0);
    idle(0);
    chk("post-flush valid", 32'(s_irv), 32'h1);
    chk("post-flush data", s_ird, 32'hC0DE_000D);

    // Alternating accepts, no gaps
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0) step(1, rand_addr(), 0, 0, 0, 0, 0);
      else            step(0, 0, 0, 1, 0, rand_addr(), 0);
      if (k > 0) begin
        chk("alt one rsp", 32'(s_irv) + 32'(s_drv), 32'h1);
        chk("alt rsp port", 32'(s_irv), 32'(k % 2));
      end
    end
    idle(0);

    // Reset asserted during a data write accept, with a response due
    step(1, 32'h8000_0044, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    step(0, 0, 0, 1, 1, 32'h8000_0040, 32'hBAD0_BAD0);
    chk("rst we", 32'(s_we), 32'h0);
    chk("rst dat_ready", 32'(s_dr), 32'h0);
    chk("rst ins_rsp_valid", 32'(s_irv), 32'h0);
    chk("rst dat_rsp_valid", 32'(s_drv), 32'h0);
    chk("rst ins_rsp_data", s_ird, 32'h0);
    chk("rst dat_rsp_data", s_drd, 32'h0);
    chk("rst mem_addres", s_addr, 32'h0);
    rst_n = 1'b1;
    step(0, 0, 0, 1, 0, 32'h8000_0040, 0);
    idle(0);
    chk("post-rst old word", s_drd, 32'hC0DE_0010);

    // Randomised traffic against the model
    ri_v = 0; rd_v = 0; rd_we = 0; ri_a = 0; rd_a = 0; rd_w = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!ri_v && $urandom_range(0, 99) < 60) begin ri_v = 1; ri_a = rand_addr(); end
      if (!rd_v && $urandom_range(0, 99) < 60) begin
        rd_v = 1; rd_we = 1'($urandom_range(0, 1)); rd_a = rand_addr(); rd_w = $urandom;
      end
      step(ri_v, ri_a, ($urandom_range(0, 9) == 0), rd_v, rd_we, rd_a, rd_w);
      if (g_ir) ri_v = 0;
      if (g_dr) rd_v = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
